md5_step_sched: RTL and testbench
=================================

MD5_STEP_SCHED -- requirements
Module: md5_step_sched

Interface
REQ-001 The block SHALL have parameter NUM_STEPS, default 64, meaning the number of compression steps per block; legal values are 16, 32, 48 and 64.
REQ-002 The block SHALL have parameter STEP_CNT_W, default 6, meaning the width of the step counter.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Rst_N  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-005 BlkValid  input  1  SHALL indicate that a 512-bit message block is presented.
REQ-006 FirstBlk  input  1  SHALL mark the block as the first of a message; it is sampled on accept.
REQ-007 BlkReady  output  1  SHALL indicate that the scheduler accepts a block.
REQ-008 Busy  output  1  SHALL be high in every state except IDLE.
REQ-009 WorkLoadEn  output  1  SHALL load working registers A/B/C/D.
REQ-010 IvSel  output  1  SHALL select IV constants (instead of state registers) as the load source.
REQ-011 StepEn  output  1  SHALL be the working-register update strobe for one step.
REQ-012 StepIdx  output  STEP_CNT_W  SHALL be the current step number i.
REQ-013 RoundSel  output  2  SHALL select the F/G/H/I function.
REQ-014 MsgIdx  output  4  SHALL be the message word index g.
REQ-015 ShiftAmt  output  5  SHALL be the rotate amount.
REQ-016 StateLoadEn  output  1  SHALL load the state registers from the ResState adder outputs.
REQ-017 DigestValid  output  1  SHALL indicate that the state registers hold the digest of the accepted block.
REQ-018 DigestReady  input  1  SHALL be the consumer's acknowledge of DigestValid.

Function
REQ-019 The FSM SHALL have exactly five states: IDLE, INIT, STEP, FINAL, DONE.
REQ-020 In IDLE, BlkReady SHALL be 1; when BlkValid and BlkReady are both high, the FSM SHALL go to INIT and capture FirstBlk.
REQ-021 INIT SHALL last 1 cycle: WorkLoadEn=1, IvSel=captured FirstBlk, StepIdx cleared to 0; next state STEP.
REQ-022 STEP SHALL assert StepEn for NUM_STEPS enabled cycles with StepIdx=0..NUM_STEPS-1, incrementing by 1 per enabled cycle.
REQ-023 After the StepEn cycle with StepIdx=NUM_STEPS-1, the FSM SHALL go to FINAL.
REQ-024 FINAL SHALL last 1 cycle with StateLoadEn=1; next state DONE.
REQ-025 In DONE, DigestValid SHALL be 1 until a cycle with DigestReady=1, after which the FSM SHALL go to IDLE.
REQ-026 DigestReady already high on DONE entry SHALL give a 1-cycle DigestValid.
REQ-027 RoundSel SHALL equal StepIdx[5:4].
REQ-028 MsgIdx SHALL be, modulo 16: round0 = i; round1 = 5i+1; round2 = 3i+5; round3 = 7i.
REQ-029 ShiftAmt SHALL be indexed by StepIdx[1:0]: round0 {7,12,17,22}; round1 {5,9,14,20}; round2 {4,11,16,23}; round3 {6,10,15,21}.
REQ-030 RoundSel, MsgIdx and ShiftAmt SHALL be combinational from StepIdx.
REQ-031 All strobes (WorkLoadEn, StepEn, StateLoadEn) SHALL be registered-state decodes, mutually exclusive, and 0 outside their states.
REQ-032 Latency from accept to DigestValid SHALL be NUM_STEPS+3 cycles when no stalls occur.
REQ-033 BlkValid SHALL be ignored whenever the FSM is not in IDLE; no block is queued.
REQ-034 DigestReady SHALL be ignored outside DONE.
REQ-035 StepIdx SHALL never wrap within a block.

Reset
REQ-036 On Rst_N low, the FSM SHALL enter IDLE immediately, regardless of current state, including mid-STEP.
REQ-037 Reset values SHALL be: StepIdx=0, captured FirstBlk=0, BlkReady=1, and Busy, WorkLoadEn, IvSel, StepEn, StateLoadEn, DigestValid all 0.
REQ-038 A block in progress when reset asserts SHALL be discarded without StateLoadEn.

Configuration
REQ-039 With macro MD5_STEP_STALL_EN defined, the block SHALL add input StepStall (1 bit); while StepStall=1 in STEP, StepEn SHALL be 0 and StepIdx SHALL hold.
REQ-040 With MD5_STEP_STALL_EN defined, StepStall SHALL have no effect in other states.
REQ-041 Without MD5_STEP_STALL_EN, port StepStall SHALL be absent and STEP SHALL last exactly NUM_STEPS cycles.

Verification
REQ-042 Reset, then BlkValid=1, FirstBlk=1, DigestReady=1 -> INIT with IvSel=1; 64 StepEn cycles; StateLoadEn; DigestValid exactly 67 cycles after accept, high for 1 cycle.
REQ-043 During a 64-step run, sample each StepEn cycle -> StepIdx=17 gives MsgIdx=6, ShiftAmt=9; StepIdx=35 gives MsgIdx=14, ShiftAmt=23; StepIdx=50 gives MsgIdx=14, ShiftAmt=15.
REQ-044 FirstBlk=0 block with DigestReady held 0 for 10 cycles -> IvSel=0 in INIT; DigestValid held 10 cycles; BlkValid pulses during Busy ignored (BlkReady=0).
REQ-045 Rst_N pulsed low at StepIdx=30 -> outputs at reset values immediately; StateLoadEn never asserted; next block restarts at StepIdx=0.
REQ-046 With MD5_STEP_STALL_EN, StepStall=1 for 5 cycles at StepIdx=20 -> StepIdx holds at 20; DigestValid 72 cycles after accept.
REQ-047 With NUM_STEPS=16 -> 16 StepEn cycles with RoundSel=0 only; DigestValid 19 cycles after accept.

Source files
------------

// File: rtl/md5_step_sched.sv
// MD5 compression-step scheduler: sequences load, NUM_STEPS round steps, state update and digest handshake.
// Optional macro MD5_STEP_STALL_EN adds the StepStall input that freezes the step sequence.
module md5_step_sched #(
  parameter int NUM_STEPS  = 64,
  parameter int STEP_CNT_W = 6
) (
  input  logic                  Clk,
  input  logic                  Rst_N,
  input  logic                  BlkValid,
  input  logic                  FirstBlk,
  output logic                  BlkReady,
  output logic                  Busy,
  output logic                  WorkLoadEn,
  output logic                  IvSel,
  output logic                  StepEn,
  output logic [STEP_CNT_W-1:0] StepIdx,
  output logic [1:0]            RoundSel,
  output logic [3:0]            MsgIdx,
  output logic [4:0]            ShiftAmt,
  output logic                  StateLoadEn,
  output logic                  DigestValid,
`ifdef MD5_STEP_STALL_EN
  input  logic                  StepStall,
`endif
  input  logic                  DigestReady
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_STEP  = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [STEP_CNT_W-1:0]   r_step_idx;
  logic                    r_first_blk;
  logic                    w_stall;
  logic                    w_last;
  logic [5:0]              w_idx6;
  logic [3:0]              w_i4;

`ifdef MD5_STEP_STALL_EN
  assign w_stall = StepStall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_last = (r_step_idx == STEP_CNT_W'(NUM_STEPS - 1));

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (BlkValid)              w_next = S_INIT;
      S_INIT:                             w_next = S_STEP;
      S_STEP:  if (!w_stall && w_last)    w_next = S_FINAL;
      S_FINAL:                            w_next = S_DONE;
      S_DONE:  if (DigestReady)           w_next = S_IDLE;
      default:                            w_next = S_IDLE;
    endcase
  end

  always_comb begin
    BlkReady    = (r_state == S_IDLE);
    Busy        = (r_state != S_IDLE);
    WorkLoadEn  = (r_state == S_INIT);
    IvSel       = (r_state == S_INIT) && r_first_blk;
    StepEn      = (r_state == S_STEP) && !w_stall;
    StateLoadEn = (r_state == S_FINAL);
    DigestValid = (r_state == S_DONE);
  end

  // The counter saturates on the last step so it never wraps within a block.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      r_step_idx <= '0;
    end else if (r_state == S_INIT) begin
      r_step_idx <= '0;
    end else if (r_state == S_STEP && !w_stall && !w_last) begin
      r_step_idx <= r_step_idx + STEP_CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      r_first_blk <= 1'b0;
    end else if (r_state == S_IDLE && BlkValid) begin
      r_first_blk <= FirstBlk;
    end
  end

  assign StepIdx  = r_step_idx;
  assign w_idx6   = 6'(r_step_idx);
  assign w_i4     = w_idx6[3:0];
  assign RoundSel = w_idx6[5:4];

  always_comb begin
    MsgIdx   = w_i4;
    ShiftAmt = 5'd0;
    case (RoundSel)
      2'd0: begin
        MsgIdx = w_i4;
        case (w_idx6[1:0])
          2'd0: ShiftAmt = 5'd7;
          2'd1: ShiftAmt = 5'd12;
          2'd2: ShiftAmt = 5'd17;
          default: ShiftAmt = 5'd22;
        endcase
      end
      2'd1: begin
        MsgIdx = (w_i4 * 4'd5) + 4'd1;
        case (w_idx6[1:0])
          2'd0: ShiftAmt = 5'd5;
          2'd1: ShiftAmt = 5'd9;
          2'd2: ShiftAmt = 5'd14;
          default: ShiftAmt = 5'd20;
        endcase
      end
      2'd2: begin
        MsgIdx = (w_i4 * 4'd3) + 4'd5;
        case (w_idx6[1:0])
          2'd0: ShiftAmt = 5'd4;
          2'd1: ShiftAmt = 5'd11;
          2'd2: ShiftAmt = 5'd16;
          default: ShiftAmt = 5'd23;
        endcase
      end
      default: begin
        MsgIdx = w_i4 * 4'd7;
        case (w_idx6[1:0])
          2'd0: ShiftAmt = 5'd6;
          2'd1: ShiftAmt = 5'd10;
          2'd2: ShiftAmt = 5'd15;
          default: ShiftAmt = 5'd21;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_md5_step_sched.sv
// Self-checking bench for md5_step_sched: 64-step and 16-step instances against a timeline reference model.
module tb_md5_step_sched;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Rst_N;
  logic       BlkValid, FirstBlk, DigestReady;
  logic       BlkReady, Busy, WorkLoadEn, IvSel, StepEn, StateLoadEn, DigestValid;
  logic [5:0] StepIdx;
  logic [1:0] RoundSel;
  logic [3:0] MsgIdx;
  logic [4:0] ShiftAmt;

  logic       b_BlkValid, b_FirstBlk, b_DigestReady;
  logic       b_BlkReady, b_Busy, b_WorkLoadEn, b_IvSel, b_StepEn, b_StateLoadEn, b_DigestValid;
  logic [5:0] b_StepIdx;
  logic [1:0] b_RoundSel;
  logic [3:0] b_MsgIdx;
  logic [4:0] b_ShiftAmt;
`ifdef MD5_STEP_STALL_EN
  logic       StepStall, b_StepStall;
`endif

  int checks   = 0;
  int failures = 0;

  md5_step_sched #(.NUM_STEPS(64), .STEP_CNT_W(6)) dut (
    .Clk(Clk), .Rst_N(Rst_N), .BlkValid(BlkValid), .FirstBlk(FirstBlk),
    .BlkReady(BlkReady), .Busy(Busy), .WorkLoadEn(WorkLoadEn), .IvSel(IvSel),
    .StepEn(StepEn), .StepIdx(StepIdx), .RoundSel(RoundSel), .MsgIdx(MsgIdx),
    .ShiftAmt(ShiftAmt), .StateLoadEn(StateLoadEn), .DigestValid(DigestValid),
`ifdef MD5_STEP_STALL_EN
    .StepStall(StepStall),
`endif
    .DigestReady(DigestReady)
  );

  md5_step_sched #(.NUM_STEPS(16), .STEP_CNT_W(6)) dut16 (
    .Clk(Clk), .Rst_N(Rst_N), .BlkValid(b_BlkValid), .FirstBlk(b_FirstBlk),
    .BlkReady(b_BlkReady), .Busy(b_Busy), .WorkLoadEn(b_WorkLoadEn), .IvSel(b_IvSel),
    .StepEn(b_StepEn), .StepIdx(b_StepIdx), .RoundSel(b_RoundSel), .MsgIdx(b_MsgIdx),
    .ShiftAmt(b_ShiftAmt), .StateLoadEn(b_StateLoadEn), .DigestValid(b_DigestValid),
`ifdef MD5_STEP_STALL_EN
    .StepStall(b_StepStall),
`endif
    .DigestReady(b_DigestReady)
  );

  function automatic logic [3:0] ref_msg(input int i);
    case (i / 16)
      0:       return 4'(i % 16);
      1:       return 4'((5 * i + 1) % 16);
      2:       return 4'((3 * i + 5) % 16);
      default: return 4'((7 * i) % 16);
    endcase
  endfunction

  function automatic logic [4:0] ref_shift(input int i);
    int t[4];
    case (i / 16)
      0:       t = '{7, 12, 17, 22};
      1:       t = '{5, 9, 14, 20};
      2:       t = '{4, 11, 16, 23};
      default: t = '{6, 10, 15, 21};
    endcase
    return 5'(t[i % 4]);
  endfunction

  // One 64-step block; expectations come from the cycle offset since accept.
  task automatic run_block(input bit first, input int hold_in, input int stall_at,
                           input int stall_len, input bit pulses, input int abort_at);
    int N = 64;
    int hold = (hold_in < 1) ? 1 : hold_in;
    int D = N + 3 + stall_len;
    int last = D + hold;
    @(posedge Clk); #1;
    BlkValid = 1'b1; FirstBlk = first; DigestReady = 1'b0;
    #1;
    checks++;
    if (BlkReady !== 1'b1) begin
      failures++; $display("FAIL accept_ready got=%b want=1", BlkReady);
    end
    for (int cnt = 1; cnt <= last; cnt++) begin
      logic [6:0] e_ctl, g_ctl;
      int k, e_idx;
      bit in_step, stalled;
      @(posedge Clk); #1;
      BlkValid    = pulses && (cnt < last) && ($urandom_range(0, 2) == 0);
      FirstBlk    = 1'($urandom_range(0, 1));
      DigestReady = (cnt < D) ? 1'($urandom_range(0, 1)) : (cnt >= D + hold - 1);
`ifdef MD5_STEP_STALL_EN
      if (cnt >= 2 + stall_at && cnt < 2 + stall_at + stall_len) StepStall = 1'b1;
      else if (cnt < 2 || cnt >= N + 2 + stall_len)           StepStall = 1'($urandom_range(0, 1));
      else                                                     StepStall = 1'b0;
`endif
      #1;
      k       = cnt - 2;
      in_step = (cnt >= 2) && (cnt < N + 2 + stall_len);
      stalled = in_step && (k >= stall_at) && (k < stall_at + stall_len);
      e_idx   = (k < stall_at) ? k : (stalled ? stall_at : k - stall_len);
      e_ctl   = {cnt == last, cnt != last, cnt == 1, (cnt == 1) && first,
                 in_step && !stalled, cnt == N + 2 + stall_len, (cnt >= D) && (cnt < last)};
      g_ctl   = {BlkReady, Busy, WorkLoadEn, IvSel, StepEn, StateLoadEn, DigestValid};
      checks++;
      if (g_ctl !== e_ctl) begin
        failures++; $display("FAIL ctrl cnt=%0d got=%b want=%b", cnt, g_ctl, e_ctl);
      end
      if (in_step) begin
        checks++;
        if (StepIdx !== 6'(e_idx) || RoundSel !== 2'(e_idx / 16) ||
            MsgIdx !== ref_msg(e_idx) || ShiftAmt !== ref_shift(e_idx)) begin
          failures++;
          $display("FAIL step cnt=%0d got idx=%0d rs=%0d g=%0d s=%0d want idx=%0d rs=%0d g=%0d s=%0d",
                   cnt, StepIdx, RoundSel, MsgIdx, ShiftAmt, e_idx, e_idx / 16,
                   ref_msg(e_idx), ref_shift(e_idx));
        end
        if (!stalled && (e_idx == 17 || e_idx == 35 || e_idx == 50)) begin
          logic [3:0] wg; logic [4:0] ws;
          wg = (e_idx == 17) ? 4'd6 : 4'd14;
          ws = (e_idx == 17) ? 5'd9 : ((e_idx == 35) ? 5'd23 : 5'd15);
          checks++;
          if (MsgIdx !== wg || ShiftAmt !== ws) begin
            failures++;
            $display("FAIL known_point idx=%0d got g=%0d s=%0d want g=%0d s=%0d",
                     e_idx, MsgIdx, ShiftAmt, wg, ws);
          end
        end
      end
      if (cnt == abort_at) return;
    end
    BlkValid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    logic [6:0] g_ctl;
    g_ctl = {BlkReady, Busy, WorkLoadEn, IvSel, StepEn, StateLoadEn, DigestValid};
    checks++;
    if (g_ctl !== 7'b1000000 || StepIdx !== 6'd0) begin
      failures++; $display("FAIL %s got ctl=%b idx=%0d want ctl=1000000 idx=0", tag, g_ctl, StepIdx);
    end
  endtask

  task automatic test_reset();
    Rst_N = 1'b0;
    BlkValid = 1'b0; FirstBlk = 1'b0; DigestReady = 1'b0;
    b_BlkValid = 1'b0; b_FirstBlk = 1'b0; b_DigestReady = 1'b0;
`ifdef MD5_STEP_STALL_EN
    StepStall = 1'b0; b_StepStall = 1'b0;
`endif
    repeat (3) @(posedge Clk);
    #2;
    check_reset_vals("reset64");
    checks++;
    if ({b_BlkReady, b_Busy, b_WorkLoadEn, b_IvSel, b_StepEn, b_StateLoadEn, b_DigestValid} !== 7'b1000000
        || b_StepIdx !== 6'd0) begin
      failures++; $display("FAIL reset16 got rdy=%b busy=%b idx=%0d want rdy=1 busy=0 idx=0",
                           b_BlkReady, b_Busy, b_StepIdx);
    end
    @(negedge Clk); Rst_N = 1'b1;
  endtask

  task automatic test_basic();
    run_block(1'b1, 1, 0, 0, 1'b0, -1);
  endtask

  task automatic test_digest_hold();
    run_block(1'b0, 10, 0, 0, 1'b1, -1);
  endtask

  task automatic test_random_blocks();
    for (int b = 0; b < 4; b++)
      run_block(1'($urandom_range(0, 1)), $urandom_range(1, 6), 0, 0, 1'b1, -1);
  endtask

  task automatic test_reset_mid_step();
    run_block(1'b1, 1, 0, 0, 1'b0, 32);
    #1; Rst_N = 1'b0;
    #1; check_reset_vals("reset_mid_step");
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #2;
      checks++;
      if (StateLoadEn !== 1'b0 || Busy !== 1'b0) begin
        failures++; $display("FAIL reset_hold got sload=%b busy=%b want 0 0", StateLoadEn, Busy);
      end
    end
    @(negedge Clk); Rst_N = 1'b1;
    run_block(1'b0, 2, 0, 0, 1'b0, -1);
  endtask

`ifdef MD5_STEP_STALL_EN
  task automatic test_stall();
    run_block(1'b1, 1, 20, 5, 1'b0, -1);
    StepStall = 1'b0;
  endtask
`endif

  task automatic test_n16();
    int steps = 0, dv_first = -1, dv_cnt = 0;
    @(posedge Clk); #1;
    b_BlkValid = 1'b1; b_FirstBlk = 1'b1; b_DigestReady = 1'b1;
    #1;
    checks++;
    if (b_BlkReady !== 1'b1) begin
      failures++; $display("FAIL n16_accept got=%b want=1", b_BlkReady);
    end
    for (int cnt = 1; cnt <= 30; cnt++) begin
      @(posedge Clk); #1;
      b_BlkValid = 1'b0;
      #1;
      if (b_StepEn) begin
        checks++;
        if (b_RoundSel !== 2'd0 || b_StepIdx !== 6'(steps)) begin
          failures++; $display("FAIL n16_step got rs=%0d idx=%0d want rs=0 idx=%0d",
                               b_RoundSel, b_StepIdx, steps);
        end
        steps++;
      end
      if (b_DigestValid) begin
        dv_cnt++;
        if (dv_first < 0) dv_first = cnt;
      end
    end
    checks++;
    if (steps != 16) begin
      failures++; $display("FAIL n16_steps got=%0d want=16", steps);
    end
    checks++;
    if (dv_first != 19 || dv_cnt != 1) begin
      failures++; $display("FAIL n16_latency got first=%0d len=%0d want first=19 len=1", dv_first, dv_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_digest_hold();
    test_random_blocks();
    test_reset_mid_step();
`ifdef MD5_STEP_STALL_EN
    test_stall();
`endif
    test_n16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
